dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (dmem: 12-bit address, 32-bit data, wren, registered q)
//  between two requesters: port 0 = processor load/store path, port 1 = DMA/debug loader.
//  Round-robin arbitration with optional bounded lock for bursts; read data is routed back
//  to the issuing port via a latency-matched tag pipeline. Sits between requesters and dmem.
// PARAMETERS
//  ADDR_W    12  dmem address width
//  DATA_W    32  dmem data width
//  RD_LAT    1   cycles from issued read to valid q_dmem (1..4)
//  MAX_HOLD  8   max consecutive grants to a locking port before forced handoff (>=1)
// PORTS
//  clock         in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high
//  p0_req        in   1       port 0 access request
//  p0_wren       in   1       port 0 write (1) / read (0)
//  p0_lock       in   1       port 0 requests to keep grant on following cycles
//  p0_addr       in   ADDR_W  port 0 address
//  p0_wdata      in   DATA_W  port 0 write data
//  p0_gnt        out  1       port 0 access issued this cycle
//  p0_rvalid     out  1       port 0 read data valid
//  p0_rdata      out  DATA_W  port 0 read data
//  p1_*          (same set as p0_*, for port 1)
//  address_dmem  out  ADDR_W  to dmem address
//  data          out  DATA_W  to dmem write data
//  wren          out  1       to dmem write enable
//  q_dmem        in   DATA_W  from dmem read data
// BEHAVIOUR
//  - One access issued per cycle max; gnt is combinational from req + state, same cycle.
//  - State: last_win (1b), lock_own (none/p0/p1), hold_cnt ($clog2(MAX_HOLD+1)b),
//    rtag pipeline RD_LAT deep of {valid, port}.
//  - Reset: last_win=1 (p0 wins first tie), lock_own=none, hold_cnt=0, rtag cleared.
//    While reset high: p0_gnt=p1_gnt=0, wren=0, rvalid=0, address_dmem=0, data=0.
//  - Winner selection, priority order:
//    1. lock_own=pX and pX_req and hold_cnt<MAX_HOLD -> pX.
//    2. only one req -> that port.
//    3. both req -> port != last_win.
//    4. none -> no grant; wren=0, address_dmem/data hold 0.
//  - On grant to pX: address_dmem=pX_addr, data=pX_wdata, wren=pX_wren; last_win<=X.
//  - Lock: if winner asserts pX_lock -> lock_own<=X, hold_cnt<=hold_cnt+1 (or 1 on new owner).
//    Lock released (lock_own<=none, hold_cnt<=0) when owner drops req or lock, or when
//    hold_cnt reaches MAX_HOLD and other port is requesting (forced handoff that cycle).
//    If hold_cnt=MAX_HOLD and other port idle, owner keeps grant; hold_cnt saturates.
//  - Reads: granted read pushes {1,X} into rtag; RD_LAT cycles later pX_rvalid=1 and
//    pX_rdata=q_dmem for exactly one cycle. Writes push {0,-}: no rvalid. Non-owning
//    port's rdata holds 0. Responses return in issue order; no backpressure.
//  - Back-to-back reads from alternating ports each return to their own port.
//  - Reset mid-operation: in-flight rtag entries dropped, no rvalid after reset edge.
//  - Requester must hold addr/wdata/wren stable while req=1 and gnt=0.
// TESTING
//  1. Reset held 2 cycles with both reqs high -> no gnt, wren=0; first cycle after: p0_gnt=1.
//  2. Both req reads continuously, no lock -> grants alternate p0,p1,p0,p1; each rvalid
//     RD_LAT later on matching port with data preloaded at that address.
//  3. p1 write addr 0x010 data 0xDEADBEEF, then p0 read 0x010 -> p0_rdata=0xDEADBEEF,
//     p1_rvalid never asserted.
//  4. p0_lock=1 and both req, MAX_HOLD=8 -> p0 granted 8 consecutive, then p1 granted;
//     with p1 idle, p0 granted indefinitely.
//  5. Reset asserted 1 cycle after p0 read issued (RD_LAT=2) -> no p0_rvalid, state cleared.
//  6. Single requester p1 only, 16 reads addr 0..15 -> p1_gnt every cycle, 16 in-order rvalids.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory, with a bounded
// grant lock for bursts and a tag pipeline that routes registered read data to its issuer.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_P0   = 2'd1,
        LOCK_P1   = 2'd2
    } lock_t;

    lock_t             r_lock_own, w_lock_own_next;
    logic              r_last_win, w_last_win_next;
    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;
    logic              w_gnt0, w_gnt1, w_any_gnt, w_win_lock;
    logic [RD_LAT-1:0] r_tag_valid;
    logic [RD_LAT-1:0] r_tag_port;
    logic              w_rsp_valid;

    // Winner selection: an unexpired lock beats round-robin; reset blocks every grant.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (r_lock_own == LOCK_P0 && p0_req && r_hold_cnt < HOLD_MAX) begin
                w_gnt0 = 1'b1;
            end else if (r_lock_own == LOCK_P1 && p1_req && r_hold_cnt < HOLD_MAX) begin
                w_gnt1 = 1'b1;
            end else if (p0_req && p1_req) begin
                w_gnt0 = r_last_win;
                w_gnt1 = !r_last_win;
            end else begin
                w_gnt0 = p0_req;
                w_gnt1 = p1_req;
            end
        end
    end

    assign w_any_gnt  = w_gnt0 | w_gnt1;
    assign w_win_lock = w_gnt0 ? p0_lock : p1_lock;
    assign p0_gnt     = w_gnt0;
    assign p1_gnt     = w_gnt1;

    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (w_gnt0) begin
            address_dmem = p0_addr;
            data         = p0_wdata;
            wren         = p0_wren;
        end else if (w_gnt1) begin
            address_dmem = p1_addr;
            data         = p1_wdata;
            wren         = p1_wren;
        end
    end

    // Any cycle where the winner does not ask to lock (or nobody wins) drops the lock.
    always_comb begin
        w_last_win_next = r_last_win;
        w_lock_own_next = LOCK_NONE;
        w_hold_cnt_next = '0;
        if (w_any_gnt) begin
            w_last_win_next = w_gnt1;
            if (w_win_lock) begin
                w_lock_own_next = w_gnt1 ? LOCK_P1 : LOCK_P0;
                if (r_lock_own == w_lock_own_next) begin
                    w_hold_cnt_next = (r_hold_cnt == HOLD_MAX) ? HOLD_MAX
                                                               : r_hold_cnt + HOLD_W'(1);
                end else begin
                    w_hold_cnt_next = HOLD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_win <= 1'b1;
            r_lock_own <= LOCK_NONE;
            r_hold_cnt <= '0;
        end else begin
            r_last_win <= w_last_win_next;
            r_lock_own <= w_lock_own_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_valid[0] <= 1'b0;
            r_tag_port[0]  <= 1'b0;
        end else begin
            r_tag_valid[0] <= w_any_gnt & !wren;
            r_tag_port[0]  <= w_gnt1;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tag
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_tag_valid[gi] <= 1'b0;
                    r_tag_port[gi]  <= 1'b0;
                end else begin
                    r_tag_valid[gi] <= r_tag_valid[gi-1];
                    r_tag_port[gi]  <= r_tag_port[gi-1];
                end
            end
        end
    endgenerate

    assign w_rsp_valid = r_tag_valid[RD_LAT-1] & !reset;
    assign p0_rvalid   = w_rsp_valid & !r_tag_port[RD_LAT-1];
    assign p1_rvalid   = w_rsp_valid &  r_tag_port[RD_LAT-1];
    assign p0_rdata    = p0_rvalid ? q_dmem : '0;
    assign p1_rdata    = p1_rvalid ? q_dmem : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural arbitration and
// memory model; one line printed per issued access.
module tb_dmem_arbiter;
    localparam int AW       = 12;
    localparam int DW       = 32;
    localparam int RD_LAT   = 2;
    localparam int MAX_HOLD = 8;

    logic          clk;
    logic          reset;
    logic          p0_req, p0_wren, p0_lock, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_wren, p1_lock, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] address_dmem;
    logic [DW-1:0] data, q_dmem;
    logic          wren;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
        .clock(clk), .reset(reset),
        .p0_req(p0_req), .p0_wren(p0_wren), .p0_lock(p0_lock), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wren(p1_wren), .p1_lock(p1_lock), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return (32'h9E3779B9 * 32'(a + 1)) ^ 32'h5A5A0000;
    endfunction

    // Memory with registered read followed by RD_LAT-1 extra delay stages.
    logic [DW-1:0] mem      [1 << AW];
    bit            mem_set  [1 << AW];
    logic [DW-1:0] q_pipe   [RD_LAT];
    always @(posedge clk) begin
        if (wren) begin
            mem[address_dmem]     <= data;
            mem_set[address_dmem] <= 1'b1;
        end
        q_pipe[0] <= mem_set[address_dmem] ? mem[address_dmem] : init_word(int'(address_dmem));
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign q_dmem = q_pipe[RD_LAT-1];

    typedef struct {
        int            port;
        logic [DW-1:0] value;
        int            due;
    } rsp_t;

    logic [DW-1:0] ref_mem [1 << AW];
    rsp_t          exp_q[$];
    int            m_last, m_owner, m_run, cyc;
    int            n_tests, n_fail;

    bit            pr_req [2];
    bit            pr_wr  [2];
    bit            pr_lk  [2];
    logic [AW-1:0] pr_a   [2];
    logic [DW-1:0] pr_d   [2];

    int            g_win;
    bit            obs_g0, obs_g1;
    int            cnt_gnt [2];
    int            cnt_rv  [2];
    logic [DW-1:0] last_rd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick();
        if (m_owner >= 0 && pr_req[m_owner] && m_run < MAX_HOLD) return m_owner;
        if (pr_req[0] && pr_req[1]) return 1 - m_last;
        if (pr_req[0]) return 0;
        if (pr_req[1]) return 1;
        return -1;
    endfunction

    task automatic do_cycle(input bit rst);
        int            win;
        bit            e_wr, e_rv0, e_rv1;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d, e_rd0, e_rd1;
        rsp_t          r;
        reset    = rst;
        p0_req   = pr_req[0]; p0_wren = pr_wr[0]; p0_lock = pr_lk[0];
        p0_addr  = pr_a[0];   p0_wdata = pr_d[0];
        p1_req   = pr_req[1]; p1_wren = pr_wr[1]; p1_lock = pr_lk[1];
        p1_addr  = pr_a[1];   p1_wdata = pr_d[1];
        @(negedge clk);
        win  = rst ? -1 : pick();
        e_wr = (win >= 0) ? pr_wr[win] : 1'b0;
        e_a  = (win >= 0) ? pr_a[win]  : '0;
        e_d  = (win >= 0) ? pr_d[win]  : '0;
        check_eq("p0_gnt", 32'(p0_gnt), 32'(win == 0));
        check_eq("p1_gnt", 32'(p1_gnt), 32'(win == 1));
        check_eq("wren", 32'(wren), 32'(e_wr));
        check_eq("address_dmem", 32'(address_dmem), 32'(e_a));
        check_eq("data", data, e_d);
        e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
        if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            if (r.port == 0) begin e_rv0 = 1; e_rd0 = r.value; end
            else             begin e_rv1 = 1; e_rd1 = r.value; end
        end
        check_eq("p0_rvalid", 32'(p0_rvalid), 32'(e_rv0));
        check_eq("p1_rvalid", 32'(p1_rvalid), 32'(e_rv1));
        check_eq("p0_rdata", p0_rdata, e_rd0);
        check_eq("p1_rdata", p1_rdata, e_rd1);
        obs_g0 = p0_gnt;
        obs_g1 = p1_gnt;
        if (p0_gnt) cnt_gnt[0]++;
        if (p1_gnt) cnt_gnt[1]++;
        if (p0_rvalid) begin cnt_rv[0]++; last_rd0 = p0_rdata; end
        if (p1_rvalid) cnt_rv[1]++;
        if (win >= 0)
            $display("[TB] cyc %0d p%0d %s addr=%h wdata=%h lock=%0d", cyc, win,
                     pr_wr[win] ? "WR" : "RD", pr_a[win], pr_d[win], pr_lk[win]);
        @(posedge clk);
        if (rst) begin
            m_last = 1; m_owner = -1; m_run = 0;
            exp_q.delete();
        end else if (win >= 0) begin
            if (pr_wr[win]) begin
                ref_mem[pr_a[win]] = pr_d[win];
            end else begin
                r.port = win; r.value = ref_mem[pr_a[win]]; r.due = cyc + RD_LAT;
                exp_q.push_back(r);
            end
            m_last = win;
            if (pr_lk[win]) begin
                if (m_owner == win) m_run = (m_run < MAX_HOLD) ? m_run + 1 : MAX_HOLD;
                else begin m_owner = win; m_run = 1; end
            end else begin
                m_owner = -1; m_run = 0;
            end
        end else begin
            m_owner = -1; m_run = 0;
        end
        g_win = win;
        cyc++;
        #1;
    endtask

    task automatic set_req(input int p, input bit rq, input bit wr, input bit lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        pr_req[p] = rq; pr_wr[p] = wr; pr_lk[p] = lk; pr_a[p] = a; pr_d[p] = d;
    endtask

    task automatic idle(input int n);
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0);
        for (int i = 0; i < n; i++) do_cycle(0);
    endtask

    initial begin
        int snap, run, best;
        n_tests = 0; n_fail = 0; cyc = 0;
        m_last = 1; m_owner = -1; m_run = 0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);

        // Reset held two cycles with both requesting, then p0 takes the first tie.
        set_req(0, 1, 0, 0, 12'h005, '0);
        set_req(1, 1, 0, 0, 12'h006, '0);
        do_cycle(1);
        do_cycle(1);
        do_cycle(0);
        check_eq("t1_first_p0_gnt", 32'(obs_g0), 32'd1);
        set_req(0, 1, 0, 0, 12'($urandom_range(0, 63)), '0);

        // Continuous reads from both ports alternate.
        for (int i = 0; i < 10; i++) begin
            do_cycle(0);
            check_eq("t2_alternate", 32'(obs_g1), 32'(i % 2 == 0));
            set_req(g_win, 1, 0, 0, 12'($urandom_range(0, 63)), '0);
        end
        idle(3);

        // p1 writes, p0 reads the same word back.
        snap = cnt_rv[1];
        set_req(1, 1, 1, 0, 12'h010, 32'hDEADBEEF);
        do_cycle(0);
        set_req(1, 0, 0, 0, '0, '0);
        set_req(0, 1, 0, 0, 12'h010, '0);
        do_cycle(0);
        idle(3);
        check_eq("t3_rdata", last_rd0, 32'hDEADBEEF);
        check_eq("t3_p1_rvalid_cnt", 32'(cnt_rv[1] - snap), 32'd0);

        // Locked burst limited to MAX_HOLD when the other port waits.
        set_req(0, 1, 0, 1, 12'h020, '0);
        set_req(1, 1, 0, 0, 12'h030, '0);
        run = 0; best = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(0);
            run  = obs_g0 ? run + 1 : 0;
            best = (run > best) ? run : best;
            if (g_win >= 0) pr_a[g_win] = pr_a[g_win] + 12'd1;
        end
        check_eq("t4_max_burst", 32'(best), 32'(MAX_HOLD));
        set_req(1, 0, 0, 0, '0, '0);
        snap = cnt_gnt[0];
        for (int i = 0; i < 12; i++) do_cycle(0);
        check_eq("t4_p0_solo_gnts", 32'(cnt_gnt[0] - snap), 32'd12);
        set_req(1, 1, 0, 0, 12'h031, '0);
        do_cycle(0);
        check_eq("t4_handoff_p1", 32'(obs_g1), 32'd1);
        idle(3);

        // Reset one cycle after a read issue drops the response and the round-robin state.
        set_req(0, 1, 0, 0, 12'h040, '0);
        do_cycle(0);
        set_req(0, 0, 0, 0, '0, '0);
        snap = cnt_rv[0];
        do_cycle(1);
        idle(4);
        check_eq("t5_no_rvalid", 32'(cnt_rv[0] - snap), 32'd0);
        set_req(0, 1, 0, 0, 12'h041, '0);
        set_req(1, 1, 0, 0, 12'h042, '0);
        do_cycle(0);
        check_eq("t5_tie_to_p0", 32'(obs_g0), 32'd1);
        idle(4);

        // Single requester streams 16 reads.
        snap = cnt_rv[1];
        run  = cnt_gnt[1];
        for (int i = 0; i < 16; i++) begin
            set_req(1, 1, 0, 0, 12'(i), '0);
            do_cycle(0);
        end
        idle(4);
        check_eq("t6_gnt_cnt", 32'(cnt_gnt[1] - run), 32'd16);
        check_eq("t6_rvalid_cnt", 32'(cnt_rv[1] - snap), 32'd16);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit rst;
            rst = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < 2; p++) begin
                if (!pr_req[p] && $urandom_range(0, 3) != 0)
                    set_req(p, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            12'($urandom_range(0, 31)), $urandom);
                else if (pr_req[p])
                    pr_lk[p] = ($urandom_range(0, 3) != 0);
            end
            do_cycle(rst);
            if (g_win >= 0) pr_req[g_win] = 0;
        end
        idle(RD_LAT + 2);
        check_eq("rsp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
